// File: rtl/sram_pkg.sv
// sram_pkg: supply/threshold levels, write-driver state encoding and timing helpers.
package sram_pkg;
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} wr_state_t;

    function automatic logic to_bit(real v);
        return v >= VTH;
    endfunction
endpackage

// File: rtl/wr_drv_seq_if.sv
// wr_drv_seq_if: request/data/mask in, status and bitline drive out.
interface wr_drv_seq_if #(parameter int COLS = 8);
    logic             req;
    real              data_in [0:COLS-1];
    logic [COLS-1:0]  mask;
    logic             ready;
    logic             wr_en;
    logic             done;
    real              bl_wr [0:COLS-1];
    real              blb_wr [0:COLS-1];

    modport master (output req, data_in, mask, input ready, wr_en, done, bl_wr, blb_wr);
    modport slave (input req, data_in, mask, output ready, wr_en, done, bl_wr, blb_wr);
endinterface

// File: rtl/wr_drv_seq_wd_col.sv
// wd_col: one column's bitline pair; drives the latched bit when enabled, else precharges both lines.
module wd_col
    import sram_pkg::*;
(
    input  logic b,
    input  logic col_en,
    input  logic drive,
    output real  bl,
    output real  blb
);
    always_comb begin
        bl = (drive && col_en && !b) ? VSS : VDD;
        blb = (drive && col_en && b) ? VSS : VDD;
    end
endmodule

// File: rtl/wr_drv_seq.sv
// wr_drv_seq: latches a thresholded write word, then sequences setup, write pulse and bitline recovery.
module wr_drv_seq
    import sram_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int PRE_CYC   = 1
) (
    input logic clk,
    input logic rst,
    wr_drv_seq_if.slave bus
);
    if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
        PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_param
        $error("wr_drv_seq: SETUP_CYC/PULSE_CYC/PRE_CYC must be within 1..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);

    wr_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [COLS-1:0]  bits, msk, thr;
    logic             drive, last;
    real              bl [0:COLS-1];
    real              blb [0:COLS-1];

    always_comb begin
        thr = '0;
        for (int i = 0; i < COLS; i++) thr[i] = to_bit(bus.data_in[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            msk   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req) begin
                bits <= thr;
                msk  <= bus.mask;
            end
        end
    end

    assign last = (cnt == '0);

    // One counter serves all three timed phases; it is reloaded on each phase entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = last ? '0 : cnt - 1'b1;
        case (state)
            IDLE: begin
                state_nx = bus.req ? SETUP : IDLE;
                cnt_nx   = bus.req ? SETUP_LD : '0;
            end
            SETUP: begin
                state_nx = last ? PULSE : SETUP;
                cnt_nx   = last ? PULSE_LD : cnt - 1'b1;
            end
            PULSE: begin
                state_nx = last ? RECOVER : PULSE;
                cnt_nx   = last ? PRE_LD : cnt - 1'b1;
            end
            RECOVER: begin
                state_nx = last ? IDLE : RECOVER;
                cnt_nx   = last ? '0 : cnt - 1'b1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign bus.wr_en = (state == PULSE);
    assign bus.done  = (state == RECOVER) && last;
    assign drive     = (state == SETUP) || (state == PULSE);

    for (genvar i = 0; i < COLS; i++) begin : g_col
        wd_col u_col (
            .b      (bits[i]),
            .col_en (msk[i]),
            .drive  (drive),
            .bl     (bl[i]),
            .blb    (blb[i])
        );
    end

    assign bus.bl_wr  = bl;
    assign bus.blb_wr = blb;
endmodule

// File: tb/tb_wr_drv_seq.sv
// tb_wr_drv_seq: directed write sequences with per-cycle checks of status and bitline drive.
module tb_wr_drv_seq;
    import sram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wr_drv_seq_if #(.COLS(8)) bus ();
    wr_drv_seq #(.COLS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int fails = 0;
    real ebl [0:7];
    real eblb [0:7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(string tag, logic o, logic e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_r(string tag, real o, real e);
        total++;
        assert (o == e) else begin
            fails++;
            $error("FAIL %s observed=%f expected=%f", tag, o, e);
        end
    endtask

    // Expected column levels: b is the hand-thresholded word, en the mask, drive the phase.
    task automatic expect_cyc(string tag, logic r, logic w, logic d, logic drv,
                              logic [7:0] b, logic [7:0] en);
        for (int i = 0; i < 8; i++) begin
            ebl[i]  = (drv && en[i]) ? (b[i] ? VDD : VSS) : VDD;
            eblb[i] = (drv && en[i]) ? (b[i] ? VSS : VDD) : VDD;
        end
        chk_b($sformatf("%s.ready", tag), bus.ready, r);
        chk_b($sformatf("%s.wr_en", tag), bus.wr_en, w);
        chk_b($sformatf("%s.done", tag), bus.done, d);
        for (int i = 0; i < 8; i++) begin
            chk_r($sformatf("%s.bl%0d", tag, i), bus.bl_wr[i], ebl[i]);
            chk_r($sformatf("%s.blb%0d", tag, i), bus.blb_wr[i], eblb[i]);
        end
    endtask

    initial begin
        int p;
        bus.req = 1'b0;
        bus.mask = 8'h00;
        bus.data_in = '{0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
        step();
        step();
        rst = 1'b0;
        step();
        expect_cyc("rst", 1, 0, 0, 0, 8'h00, 8'h00);

        // basic write, including the exactly-VTH and just-below-VTH columns
        bus.data_in = '{1.5, 0.0, 1.5, 0.0, 0.8, 0.79, 1.5, 0.0};
        bus.mask = 8'hFF;
        bus.req = 1'b1;
        expect_cyc("t1c0", 1, 0, 0, 0, 8'h55, 8'hFF);
        step();
        bus.req = 1'b0;
        expect_cyc("t1c1", 0, 0, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t1c2", 0, 1, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t1c3", 0, 1, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t1c4", 0, 0, 1, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t1c5", 1, 0, 0, 0, 8'h55, 8'hFF);

        // partial mask
        bus.data_in = '{1.5, 1.5, 1.5, 1.5, 1.5, 1.5, 1.5, 1.5};
        bus.mask = 8'h0F;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expect_cyc("t2c1", 0, 0, 0, 1, 8'hFF, 8'h0F);
        step();
        expect_cyc("t2c2", 0, 1, 0, 1, 8'hFF, 8'h0F);
        step();
        expect_cyc("t2c3", 0, 1, 0, 1, 8'hFF, 8'h0F);
        step();
        expect_cyc("t2c4", 0, 0, 1, 0, 8'hFF, 8'h0F);
        step();
        expect_cyc("t2c5", 1, 0, 0, 0, 8'hFF, 8'h0F);

        // input changes and a stray request during PULSE
        bus.data_in = '{1.5, 0.0, 1.5, 0.0, 0.8, 0.79, 1.5, 0.0};
        bus.mask = 8'hFF;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expect_cyc("t3c1", 0, 0, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t3c2", 0, 1, 0, 1, 8'h55, 8'hFF);
        bus.data_in = '{0.0, 1.5, 0.0, 1.5, 0.0, 1.5, 0.0, 1.5};
        bus.mask = 8'h00;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expect_cyc("t3c3", 0, 1, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t3c4", 0, 0, 1, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t3c5", 1, 0, 0, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t3c6", 1, 0, 0, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t3c7", 1, 0, 0, 0, 8'h55, 8'hFF);

        // reset in the first PULSE cycle
        bus.data_in = '{1.5, 0.0, 1.5, 0.0, 0.8, 0.79, 1.5, 0.0};
        bus.mask = 8'hFF;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expect_cyc("t4c1", 0, 0, 0, 1, 8'h55, 8'hFF);
        step();
        expect_cyc("t4c2", 0, 1, 0, 1, 8'h55, 8'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_cyc("t4c3", 1, 0, 0, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t4c4", 1, 0, 0, 0, 8'h55, 8'hFF);
        step();
        expect_cyc("t4c5", 1, 0, 0, 0, 8'h55, 8'hFF);

        // req held high: back-to-back operations
        bus.req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            p = c % 5;
            expect_cyc($sformatf("t5c%0d", c), p == 0, p == 2 || p == 3, p == 4,
                       p >= 1 && p <= 3, 8'h55, 8'hFF);
            if (c == 9) bus.req = 1'b0;
            step();
        end
        expect_cyc("t5c10", 1, 0, 0, 0, 8'h55, 8'hFF);

        // all-zero mask still pulses wr_en, every column precharged
        bus.mask = 8'h00;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int c = 1; c < 6; c++) begin
            expect_cyc($sformatf("t6c%0d", c), c == 5, c == 2 || c == 3, c == 4,
                       c >= 1 && c <= 3, 8'h55, 8'h00);
            step();
        end

        // rst and req together: request dropped
        bus.mask = 8'hFF;
        bus.req = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 1'b0;
        expect_cyc("t7c1", 1, 0, 0, 0, 8'h00, 8'h00);
        step();
        expect_cyc("t7c2", 1, 0, 0, 0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/wr_drv_seq.md
WR_DRV_SEQ -- requirements
Module: wr_drv_seq

Interface
REQ-001 Parameter COLS, default 8: number of bitline columns driven.
REQ-002 Parameter SETUP_CYC, default 1: data-setup cycles before the write pulse, range 1..15.
REQ-003 Parameter PULSE_CYC, default 2: write-enable pulse width in cycles, range 1..15.
REQ-004 Parameter PRE_CYC, default 1: bitline recovery (precharge) cycles after the pulse, range 1..15.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req  input  1  write request; qualified only while ready=1.
REQ-008 data_in  input  real [0:COLS-1]  analog data level per column.
REQ-009 mask  input  logic [COLS-1:0]  per-column write enable, 1 = write column.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 wr_en  output  1  write pulse to the array (wordline gate qualifier).
REQ-012 done  output  1  one-cycle completion strobe.
REQ-013 bl_wr  output  real [0:COLS-1]  bitline drive.
REQ-014 blb_wr  output  real [0:COLS-1]  complementary bitline drive.

Function
REQ-015 States: IDLE, SETUP, PULSE, RECOVER; a single down-counter times SETUP, PULSE and RECOVER.
REQ-016 IDLE: ready=1; on req=1, latch data_in thresholded (bit = data_in[i] >= VTH) and mask, then go to SETUP.
REQ-017 SETUP lasts SETUP_CYC cycles, then PULSE; PULSE lasts PULSE_CYC cycles, then RECOVER; RECOVER lasts PRE_CYC cycles, then IDLE.
REQ-018 wr_en=1 exactly during PULSE and at no other time.
REQ-019 In SETUP and PULSE, a masked-in column with latched bit 1 drives bl=VDD, blb=VSS; latched bit 0 drives bl=VSS, blb=VDD.
REQ-020 Masked-out columns, and all columns in IDLE and RECOVER, drive bl=VDD, blb=VDD (precharge).
REQ-021 done=1 for exactly one cycle: the last RECOVER cycle.
REQ-022 Request-to-done latency is SETUP_CYC+PULSE_CYC+PRE_CYC cycles; ready returns the cycle after done.
REQ-023 req while ready=0 is ignored and not queued; data_in and mask changes after acceptance do not affect the operation in flight.
REQ-024 mask all-zero: the full sequence still runs with wr_en pulsed, and every column stays precharged.
REQ-025 data_in exactly equal to VTH resolves to bit 1.
REQ-026 Outputs are registered; no combinational path from req or data_in to any output.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, counter=0, latched bits and mask=0, ready=1, wr_en=0, done=0, all bl_wr/blb_wr=VDD.
REQ-028 rst asserted in any state, including mid-PULSE, aborts the operation with no done strobe; wr_en falls the next edge.
REQ-029 rst and req in the same cycle: rst wins, and the request is dropped.

Structure
REQ-030 Package sram_pkg holds real constants VDD=1.5, VSS=0.0, VTH=0.8 and the state enum wr_state_t.
REQ-031 One sub-module, wd_col, maps (bit, col_en, drive) to the bl/blb real pair for one column and is instantiated COLS times via generate.
REQ-032 The counter width is 4 bits; parameter range is checked by elaboration-time assertion.

Verification (COLS=8, defaults)
REQ-033 Reset then idle: bl_wr=blb_wr=1.5 on all columns; ready=1, wr_en=0, done=0.
REQ-034 req at cycle 0 with data_in={1.5,0,1.5,0,0.8,0.79,1.5,0} and mask=8'hFF: SETUP at cycle 1; wr_en high at cycles 2-3; done at cycle 4; ready at cycle 5; during cycles 1-3 bl={1.5,0,1.5,0,1.5,0,1.5,0} and blb complementary.
REQ-035 mask=8'h0F with data all 1.5: columns 0-3 drive bl=1.5/blb=0 in cycles 1-3; columns 4-7 stay 1.5/1.5 throughout.
REQ-036 Change data_in and mask, and pulse req, during PULSE: no change to outputs in flight, exactly one done, and the second req is ignored.
REQ-037 rst at cycle 2 (first PULSE cycle): at cycle 3, wr_en=0, all lines are 1.5, ready=1, and done never asserts.
REQ-038 Back-to-back: req held high continuously gives operations accepted at cycles 0 and 5, with done at cycles 4 and 9.
